bit_serializer: RTL and testbench

Parallel-to-serial front end for the sequence-detector path. Accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock on `x`, qualified by `x_valid`. `x` feeds the Moore sequence detector's serial input directly, so it is driven low whenever no word is being shifted.

---
 rtl/seq_pkg.sv | 24 ++
 rtl/ser_hold_buf.sv | 28 ++
 rtl/bit_serializer.sv | 101 ++++++++++
 tb/tb_bit_serializer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the serializer front end and the sequence detector.
package seq_pkg;

   localparam int SER_MAX_WIDTH = 32;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } ser_state_t;

   // Moore detector for the overlapping pattern 1101.
   typedef enum logic [2:0] {
      DET_S0    = 3'd0,
      DET_S1    = 3'd1,
      DET_S11   = 3'd2,
      DET_S110  = 3'd3,
      DET_S1101 = 3'd4
   } det_state_t;

   function automatic int ser_cnt_w(input int width);
      return (width > 2) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/ser_hold_buf.sv
// One-word hold buffer for the serializer; load and drain on the same edge keeps it full.
module ser_hold_buf
   import seq_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             drain,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             full
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q    <= '0;
         full <= 1'b0;
      end else if (load) begin
         q    <= d;
         full <= 1'b1;
      end else if (drain) begin
         full <= 1'b0;
      end
   end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end feeding the sequence detector one bit per clock.
// Define SER_HOLD_BUF_EN to add a one-word hold buffer for gapless streaming.
module bit_serializer
   import seq_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             x,
   output logic             x_valid,
   output logic             busy,
   output logic             state_dbg
);

   localparam int             CW       = ser_cnt_w(WIDTH);
   localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

   // Handshake: a word moves on a rising edge where din_valid && din_ready.
   // din_ready never looks at din_valid, and is held low during reset.
   ser_state_t       state;
   logic [WIDTH-1:0] sreg;
   logic [CW-1:0]    cnt;
   logic             last;
   logic             hs;
   logic             load_word;
   logic [WIDTH-1:0] load_data;
   logic             buf_full;

   assign last = (state == SHIFT) && (cnt == '0);
   assign hs   = din_valid && din_ready;

   function automatic logic first_bit(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? w[WIDTH-1] : w[0];
   endfunction

`ifdef SER_HOLD_BUF_EN
   logic [WIDTH-1:0] buf_q;
   logic             buf_load;
   logic             buf_drain;

   assign din_ready = rst && !buf_full;
   // Words arriving mid-word park in the buffer; on the last-bit edge an empty
   // buffer lets a fresh handshake go straight into sreg.
   assign buf_load  = hs && (state == SHIFT) && !last;
   assign buf_drain = last && buf_full;
   assign load_word = (state == IDLE) ? hs : (last && (buf_full || hs));
   assign load_data = buf_full ? buf_q : din;

   ser_hold_buf #(.WIDTH(WIDTH)) u_hold_buf (
      .clk   (clk),
      .rst   (rst),
      .load  (buf_load),
      .drain (buf_drain),
      .d     (din),
      .q     (buf_q),
      .full  (buf_full)
   );
`else
   assign buf_full  = 1'b0;
   assign din_ready = rst && ((state == IDLE) || last);
   assign load_word = hs;
   assign load_data = din;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         sreg    <= '0;
         cnt     <= '0;
         x       <= 1'b0;
         x_valid <= 1'b0;
      end else if (load_word) begin
         state   <= SHIFT;
         sreg    <= load_data;
         cnt     <= CNT_LAST;
         x       <= first_bit(load_data);
         x_valid <= 1'b1;
      end else if (state == SHIFT) begin
         if (cnt == '0) begin
            state   <= IDLE;
            sreg    <= '0;
            x       <= 1'b0;
            x_valid <= 1'b0;
         end else begin
            // sreg keeps the bit on x at its edge; the next one sits one place in.
            sreg <= MSB_FIRST ? (sreg << 1) : (sreg >> 1);
            x    <= MSB_FIRST ? sreg[WIDTH-2] : sreg[1];
            cnt  <= cnt - CW'(1);
         end
      end
   end

   assign busy      = (state == SHIFT) || buf_full;
   assign state_dbg = state;

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: MSB-first and LSB-first instances share one input stream.
module tb_bit_serializer;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [W-1:0] din = '0;
   logic         din_valid = 1'b0;

   logic rdy_m, x_m, xv_m, busy_m, st_m;
   logic rdy_l, x_l, xv_l, busy_l, st_l;

   int total = 0;
   int bad   = 0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy_m),
      .x(x_m), .x_valid(xv_m), .busy(busy_m), .state_dbg(st_m)
   );

   bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy_l),
      .x(x_l), .x_valid(xv_l), .busy(busy_l), .state_dbg(st_l)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] rev(input logic [W-1:0] v);
      logic [W-1:0] r;
      for (int i = 0; i < W; i++) r[i] = v[W-1-i];
      return r;
   endfunction

   // ---------------- reference model ----------------
   // rem = word bits still to appear on x (including the one showing now);
   // cur = word being emitted. Bit shown = cur[rem-1] (MSB first) or cur[W-rem].
   int           rem = 0;
   logic [W-1:0] cur = '0;
   bit           model_hs = 1'b0;
   logic [W-1:0] exp_q[$];
`ifdef SER_HOLD_BUF_EN
   bit           bf_full = 1'b0;
   logic [W-1:0] bf_word = '0;
`endif

   function automatic bit model_ready();
`ifdef SER_HOLD_BUF_EN
      return rst && !bf_full;
`else
      return rst && (rem <= 1);
`endif
   endfunction

   function automatic bit model_busy();
`ifdef SER_HOLD_BUF_EN
      return (rem > 0) || bf_full;
`else
      return rem > 0;
`endif
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         rem = 0;
         model_hs = 1'b0;
         exp_q.delete();
`ifdef SER_HOLD_BUF_EN
         bf_full = 1'b0;
`endif
      end else begin
         model_hs = din_valid && model_ready();
         if (model_hs) exp_q.push_back(din);
`ifdef SER_HOLD_BUF_EN
         if (rem == 0) begin
            if (model_hs) begin cur = din; rem = W; end
         end else if (rem == 1) begin
            if (bf_full) begin cur = bf_word; rem = W; bf_full = 1'b0; end
            else if (model_hs) begin cur = din; rem = W; end
            else rem = 0;
         end else begin
            rem--;
            if (model_hs) begin bf_word = din; bf_full = 1'b1; end
         end
`else
         if (model_hs) begin cur = din; rem = W; end
         else if (rem > 0) rem--;
`endif
      end
   end

   // ---------------- scoreboard / monitor ----------------
   bit           chk_en = 1'b0;
   logic [W-1:0] asm_m = '0, asm_l = '0, last_m = '0, last_l = '0, sb_word;
   logic [15:0]  stream = '0;
   int           nbits = 0, run = 0, max_run = 0;

   always @(negedge clk) begin
      if (chk_en) begin
         check("x_valid_m", xv_m, rem > 0);
         check("x_valid_l", xv_l, rem > 0);
         check("x_m", x_m, (rem > 0) ? cur[rem-1] : 1'b0);
         check("x_l", x_l, (rem > 0) ? cur[W-rem] : 1'b0);
         check("din_ready_m", rdy_m, model_ready());
         check("din_ready_l", rdy_l, model_ready());
         check("busy_m", busy_m, model_busy());
         check("busy_l", busy_l, model_busy());
         check("state_m", st_m, rem > 0);
         check("state_l", st_l, rem > 0);
      end
      if (!rst) begin
         nbits = 0;
         run = 0;
      end else if (xv_m) begin
         asm_m  = {asm_m[W-2:0], x_m};
         asm_l  = {asm_l[W-2:0], x_l};
         stream = {stream[14:0], x_m};
         run++;
         nbits++;
         if (nbits == W) begin
            nbits  = 0;
            last_m = asm_m;
            last_l = asm_l;
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL sb_underflow: got=word expected=none at %0t", $time);
            end else begin
               sb_word = exp_q.pop_front();
               check("word_m", asm_m, sb_word);
               check("word_l", rev(asm_l), sb_word);
            end
         end
      end else begin
         run = 0;
      end
      if (run > max_run) max_run = run;
   end

   // ---------------- driver tasks ----------------
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic push(input logic [W-1:0] w);
      int g = 0;
      din = w;
      din_valid = 1'b1;
      while (!rdy_m && g < 50) begin
         @(negedge clk);
         #1;
         g++;
      end
      if (g >= 50) begin
         total++;
         bad++;
         $display("FAIL push_timeout: got=no_ready expected=ready at %0t", $time);
      end
      @(posedge clk);
      #1;
      din_valid = 1'b0;
   endtask

   typedef struct {
      logic [W-1:0] din;
      logic [W-1:0] seq_m;   // emission order, first bit in [W-1]
      logic [W-1:0] seq_l;
   } vec_t;

   vec_t vecs[6];

   // ---------------- test ----------------
   initial begin
      vecs[0] = '{8'hD0, 8'hD0, 8'h0B};
      vecs[1] = '{8'h0B, 8'h0B, 8'hD0};
      vecs[2] = '{8'hFF, 8'hFF, 8'hFF};
      vecs[3] = '{8'h01, 8'h01, 8'h80};
      vecs[4] = '{8'h80, 8'h80, 8'h01};
      vecs[5] = '{8'h3C, 8'h3C, 8'h3C};

      // reset held with din_valid high
      din = 8'hFF;
      din_valid = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check("rst_x", x_m, 1'b0);
      check("rst_x_valid", xv_m, 1'b0);
      check("rst_busy", busy_m, 1'b0);
      check("rst_ready_m", rdy_m, 1'b0);
      check("rst_ready_l", rdy_l, 1'b0);
      din_valid = 1'b0;
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("post_rst_ready", rdy_m, 1'b1);
      check("post_rst_state", st_m, 1'b0);
      chk_en = 1'b1;

      // table-driven single words
      for (int i = 0; i < 6; i++) begin
         push(vecs[i].din);
         cyc(W + 1);
         check("tbl_seq_m", last_m, vecs[i].seq_m);
         check("tbl_seq_l", last_l, vecs[i].seq_l);
         check("tbl_idle_x", x_m, 1'b0);
         check("tbl_idle_xv", xv_m, 1'b0);
      end

      // back-to-back, handshake on the last-bit edge
      max_run = 0;
      push(8'hD0);
      push(8'hDD);
      cyc(W + 2);
      check("b2b_run", max_run, 16);
      check("b2b_stream", stream, 16'b1101000011011101);

      // reset mid-word after three bits of 8'hFF
      push(8'hFF);
      repeat (2) @(posedge clk);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("midrst_xv", xv_m, 1'b0);
      check("midrst_x", x_m, 1'b0);
      check("midrst_busy", busy_m, 1'b0);
      check("midrst_ready", rdy_m, 1'b0);
      @(negedge clk);
      #2 rst = 1'b1;
      max_run = 0;
      cyc(W + 2);
      check("midrst_no_resume", max_run, 0);
      check("midrst_state", st_m, 1'b0);

`ifdef SER_HOLD_BUF_EN
      // word offered mid-word lands in the hold buffer
      max_run = 0;
      push(8'h3C);
      din = 8'hA5;
      din_valid = 1'b1;
      check("buf_ready_offer", rdy_m, 1'b1);
      @(posedge clk);
      #1;
      din_valid = 1'b0;
      check("buf_ready_full", rdy_m, 1'b0);
      check("buf_busy", busy_m, 1'b1);
      cyc(2 * W + 2);
      check("buf_run", max_run, 16);
      check("buf_stream", stream, 16'h3CA5);
`endif

      // randomized traffic against the model
      for (int c = 0; c < 800; c++) begin
         @(negedge clk);
         #1;
         if (!din_valid || model_hs) begin
            din_valid = ($urandom_range(0, 2) != 0);
            din = W'($urandom);
         end
      end
      din_valid = 1'b0;
      cyc(3 * W);
      check("sb_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
